execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 5-stage pipeline: consumes the ID/EX control and operand bundle produced by the decode stage, applies hazard-unit forwarding, performs the ALU operation, and resolves branches and jumps. It drives the fetch stage with the PC redirect in the same cycle. It registers the EX/MEM bundle for the memory stage.

## Interface
Parameters:
- DATA_W, 19, register/data width
- PC_W, 15, program counter width
- RA_W, 5, register address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- RegWriteE, MemWriteE, JumpE, ALUSrcE, ResultSrcE, Cant_ByteE  in  1 each  decoded controls
- BranchE  in  2  branch type
- ALUControlE  in  3  ALU operation
- RD1E, RD2E, ImmExtE  in  DATA_W  register operands, extended immediate
- PCE  in  PC_W  PC of instruction in Execute
- RDE  in  RA_W  destination register
- ForwardAE, ForwardBE  in  2  forwarding select from hazard unit
- ResultW  in  DATA_W  writeback result, forwarding source
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  PC_W  redirect target (combinational)
- RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM  out  1  registered controls
- ALUResultM  out  DATA_W  registered ALU result; also the internal forwarding source
- WriteDataM  out  DATA_W  registered store data
- RDM  out  RA_W  registered destination

## Operation
- Forward select, per operand: 00 uses RD1E/RD2E, 01 uses ResultW, 10 uses ALUResultM, 11 is reserved and behaves as 00.
- SrcA is the forwarded A.
- SrcB is ImmExtE when ALUSrcE=1, otherwise forwarded B.
- WriteData is always forwarded B, taken before the ALUSrc mux.
- ALUControlE encoding:
  - 000: add
  - 001: sub
  - 010: and
  - 011: or
  - 100: xor
  - 101: sll by SrcB[4:0]
  - 110: srl by SrcB[4:0]
  - 111: signed slt, result 1 or 0
- All arithmetic is mod 2^DATA_W.
- Shift amount ≥ DATA_W yields 0.
- Branch conditions are computed from a sub of forwarded A minus forwarded B (always register operands, independent of ALUSrcE):
  - BranchE 00: none
  - BranchE 01: beq (taken when zero)
  - BranchE 10: bne (taken when not zero)
  - BranchE 11: blt (taken when signed A<B)
- PCSrcE = JumpE | taken.
- PCTargetE = PCE + ImmExtE[PC_W-1:0], wrapping mod 2^PC_W. For example, PCE=7FFF with imm 2 gives 0001.
- JumpE and BranchE≠00 together: PCSrcE=1, same target.
- Flushing the wrong-path younger instructions is the hazard unit's job. This block never squashes its own instruction.

## Timing
- PCSrcE, PCTargetE and all ALU/forwarding logic are combinational from inputs and ALUResultM. There are no loops through ResultW.
- EX/MEM register: latency 1. All M outputs update on the rising clk edge, every cycle, with no enable.
- Reset (asynchronous, active-low): all M outputs go to 0 immediately on assertion and are held while reset=0. Assertion mid-operation discards the in-flight bundle.
- The first edge after reset deassertion captures the current inputs.
- ForwardAE=10 selects the value registered on the previous edge, i.e. back-to-back dependency with 0 stall cycles.

## Configuration
- EXECUTE_FORWARD_EN, when defined: forwarding muxes are present as specified.
- When undefined: ForwardAE/ForwardBE and ResultW are ignored (ports kept), and SrcA, SrcB and WriteData come from RD1E/RD2E directly. The hazard unit must then stall for all RAW hazards.

## Test plan
- Reset with inputs active: all M outputs read 0 while reset=0.
- After release, add with RD1E=5, RD2E=3, ALUSrcE=0: ALUResultM=8 one edge later, and RDM/RegWriteM match the inputs.
- sub with 0 − 1: ALUResultM=7FFFF. slt with A=40000 (negative), B=1: ALUResultM=1. sll with shift amount 20: ALUResultM=0.
- Branch resolution:
  - beq with A=B=9, PCE=0010, imm=0004: PCSrcE=1, PCTargetE=0014 in the same cycle.
  - bne with the same operands: PCSrcE=0.
  - JumpE with PCE=7FFF, imm=2: PCTargetE=0001.
- Forwarding (EXECUTE_FORWARD_EN defined): cycle 1 add yields ALUResultM=8. Cycle 2 with ForwardAE=10, RD1E=0, RD2E=1, add yields ALUResultM=9. With ForwardBE=01, ResultW=6, ALUSrcE=1, imm=1: WriteDataM=6 and ALUResultM=A+1.
- Macro undefined: repeat the forwarding scenario; ALUResultM=1 (forward selects ignored).

Source files
------------

// File: rtl/execute_stage.sv
// ============================================================================
// Module      : execute_stage
// Description : Pipeline Execute stage. Applies operand forwarding, runs the
//               ALU, resolves branches/jumps (combinational PC redirect) and
//               registers the EX/MEM bundle. Optional feature macro:
//               EXECUTE_FORWARD_EN (forwarding muxes present when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage #(
   parameter int DATA_W = 19,
   parameter int PC_W   = 15,
   parameter int RA_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWriteE,
   input  logic              MemWriteE,
   input  logic              JumpE,
   input  logic              ALUSrcE,
   input  logic              ResultSrcE,
   input  logic              Cant_ByteE,
   input  logic [1:0]        BranchE,
   input  logic [2:0]        ALUControlE,
   input  logic [DATA_W-1:0] RD1E,
   input  logic [DATA_W-1:0] RD2E,
   input  logic [DATA_W-1:0] ImmExtE,
   input  logic [PC_W-1:0]   PCE,
   input  logic [RA_W-1:0]   RDE,
   input  logic [1:0]        ForwardAE,
   input  logic [1:0]        ForwardBE,
   input  logic [DATA_W-1:0] ResultW,
   output logic              PCSrcE,
   output logic [PC_W-1:0]   PCTargetE,
   output logic              RegWriteM,
   output logic              MemWriteM,
   output logic              ResultSrcM,
   output logic              Cant_ByteM,
   output logic [DATA_W-1:0] ALUResultM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic [RA_W-1:0]   RDM
);

   localparam logic [1:0] c_BR_NONE = 2'b00;
   localparam logic [1:0] c_BR_BEQ  = 2'b01;
   localparam logic [1:0] c_BR_BNE  = 2'b10;
   localparam logic [1:0] c_BR_BLT  = 2'b11;

   logic [DATA_W-1:0] w_fwd_a;
   logic [DATA_W-1:0] w_fwd_b;
   logic [DATA_W-1:0] w_srcb;
   logic [DATA_W-1:0] w_alu_result;
   logic [DATA_W-1:0] w_diff;
   logic [4:0]        w_shamt;
   logic              w_shamt_big;
   logic              w_slt;
   logic              w_zero;
   logic              w_br_lt;
   logic              w_taken;

`ifdef EXECUTE_FORWARD_EN
   // Select 11 is reserved and falls back to the register-file operand.
   always_comb begin
      case (ForwardAE)
         2'b01:   w_fwd_a = ResultW;
         2'b10:   w_fwd_a = ALUResultM;
         default: w_fwd_a = RD1E;
      endcase
   end

   always_comb begin
      case (ForwardBE)
         2'b01:   w_fwd_b = ResultW;
         2'b10:   w_fwd_b = ALUResultM;
         default: w_fwd_b = RD2E;
      endcase
   end
`else
   logic w_unused_fwd;
   assign w_fwd_a      = RD1E;
   assign w_fwd_b      = RD2E;
   assign w_unused_fwd = ^{ForwardAE, ForwardBE, ResultW};
`endif

   assign w_srcb      = ALUSrcE ? ImmExtE : w_fwd_b;
   assign w_shamt     = w_srcb[4:0];
   assign w_shamt_big = (32'(w_shamt) >= DATA_W);
   assign w_slt       = ($signed(w_fwd_a) < $signed(w_srcb));

   always_comb begin
      case (ALUControlE)
         3'b000:  w_alu_result = w_fwd_a + w_srcb;
         3'b001:  w_alu_result = w_fwd_a - w_srcb;
         3'b010:  w_alu_result = w_fwd_a & w_srcb;
         3'b011:  w_alu_result = w_fwd_a | w_srcb;
         3'b100:  w_alu_result = w_fwd_a ^ w_srcb;
         3'b101:  w_alu_result = w_shamt_big ? '0 : (w_fwd_a << w_shamt);
         3'b110:  w_alu_result = w_shamt_big ? '0 : (w_fwd_a >> w_shamt);
         default: w_alu_result = {{(DATA_W-1){1'b0}}, w_slt};
      endcase
   end

   // Branch compare always uses the register operands, never the immediate.
   assign w_diff  = w_fwd_a - w_fwd_b;
   assign w_zero  = (w_diff == '0);
   assign w_br_lt = w_diff[DATA_W-1] ^
                    ((w_fwd_a[DATA_W-1] != w_fwd_b[DATA_W-1]) &&
                     (w_diff[DATA_W-1] != w_fwd_a[DATA_W-1]));

   always_comb begin
      case (BranchE)
         c_BR_NONE: w_taken = 1'b0;
         c_BR_BEQ:  w_taken = w_zero;
         c_BR_BNE:  w_taken = ~w_zero;
         c_BR_BLT:  w_taken = w_br_lt;
         default:   w_taken = 1'b0;
      endcase
   end

   assign PCSrcE    = JumpE | w_taken;
   assign PCTargetE = PCE + ImmExtE[PC_W-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= 1'b0;
         Cant_ByteM <= 1'b0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         RDM        <= '0;
      end else begin
         RegWriteM  <= RegWriteE;
         MemWriteM  <= MemWriteE;
         ResultSrcM <= ResultSrcE;
         Cant_ByteM <= Cant_ByteE;
         ALUResultM <= w_alu_result;
         WriteDataM <= w_fwd_b;
         RDM        <= RDE;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// Module      : tb_execute_stage
// Description : Directed self-checking bench for execute_stage; expectations
//               follow EXECUTE_FORWARD_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_stage;

   logic        clk;
   logic        reset;
   logic        RegWriteE, MemWriteE, JumpE, ALUSrcE, ResultSrcE, Cant_ByteE;
   logic [1:0]  BranchE;
   logic [2:0]  ALUControlE;
   logic [18:0] RD1E, RD2E, ImmExtE, ResultW;
   logic [14:0] PCE;
   logic [4:0]  RDE;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        PCSrcE;
   logic [14:0] PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM;
   logic [18:0] ALUResultM, WriteDataM;
   logic [4:0]  RDM;

   int n_vec = 0;
   int n_bad = 0;

   execute_stage dut (
      .clk        (clk),
      .reset      (reset),
      .RegWriteE  (RegWriteE),
      .MemWriteE  (MemWriteE),
      .JumpE      (JumpE),
      .ALUSrcE    (ALUSrcE),
      .ResultSrcE (ResultSrcE),
      .Cant_ByteE (Cant_ByteE),
      .BranchE    (BranchE),
      .ALUControlE(ALUControlE),
      .RD1E       (RD1E),
      .RD2E       (RD2E),
      .ImmExtE    (ImmExtE),
      .PCE        (PCE),
      .RDE        (RDE),
      .ForwardAE  (ForwardAE),
      .ForwardBE  (ForwardBE),
      .ResultW    (ResultW),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .Cant_ByteM (Cant_ByteM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .RDM        (RDM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input logic [2:0] op, input logic [18:0] a, input logic [18:0] b,
                      input logic src, input logic [18:0] imm);
      ALUControlE = op;
      RD1E        = a;
      RD2E        = b;
      ALUSrcE     = src;
      ImmExtE     = imm;
      BranchE     = 2'b00;
      JumpE       = 1'b0;
      #1;
   endtask

   task automatic br(input logic [1:0] bt, input logic jmp, input logic [18:0] a,
                     input logic [18:0] b, input logic [14:0] pc, input logic [18:0] imm);
      BranchE = bt;
      JumpE   = jmp;
      RD1E    = a;
      RD2E    = b;
      PCE     = pc;
      ImmExtE = imm;
      #1;
   endtask

   initial begin
      reset       = 1'b0;
      RegWriteE   = 1'b1;
      MemWriteE   = 1'b1;
      ResultSrcE  = 1'b1;
      Cant_ByteE  = 1'b1;
      JumpE       = 1'b0;
      ALUSrcE     = 1'b0;
      BranchE     = 2'b00;
      ALUControlE = 3'b000;
      RD1E        = 19'h5;
      RD2E        = 19'h3;
      ImmExtE     = 19'h0;
      PCE         = 15'h0;
      RDE         = 5'd7;
      ForwardAE   = 2'b00;
      ForwardBE   = 2'b00;
      ResultW     = 19'h0;

      // Reset held with live inputs across edges
      step();
      step();
      check("rst_alu",  ALUResultM, 0);
      check("rst_wd",   WriteDataM, 0);
      check("rst_rd",   RDM, 0);
      check("rst_ctl",  {RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM}, 0);

      reset = 1'b1;
      step();
      check("add_res",  ALUResultM, 19'h8);
      check("add_rd",   RDM, 5'd7);
      check("add_wd",   WriteDataM, 19'h3);
      check("add_ctl",  {RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM}, 4'hF);

      alu(3'b001, 19'h0, 19'h1, 1'b0, 19'h0);     step(); check("sub_wrap", ALUResultM, 19'h7FFFF);
      alu(3'b111, 19'h40000, 19'h1, 1'b0, 19'h0); step(); check("slt_neg",  ALUResultM, 19'h1);
      alu(3'b111, 19'h1, 19'h40000, 1'b0, 19'h0); step(); check("slt_pos",  ALUResultM, 19'h0);
      alu(3'b101, 19'h1, 19'h14, 1'b0, 19'h0);    step(); check("sll_20",   ALUResultM, 19'h0);
      alu(3'b101, 19'h3, 19'h4, 1'b0, 19'h0);     step(); check("sll_4",    ALUResultM, 19'h30);
      alu(3'b110, 19'h40000, 19'h12, 1'b0, 19'h0);step(); check("srl_18",   ALUResultM, 19'h1);
      alu(3'b110, 19'h40000, 19'h13, 1'b0, 19'h0);step(); check("srl_19",   ALUResultM, 19'h0);
      alu(3'b010, 19'h0F0F0, 19'h00FF0, 1'b0, 19'h0); step(); check("and", ALUResultM, 19'h000F0);
      alu(3'b011, 19'h0F0F0, 19'h00FF0, 1'b0, 19'h0); step(); check("or",  ALUResultM, 19'h0FFF0);
      alu(3'b100, 19'h0F0F0, 19'h00FF0, 1'b0, 19'h0); step(); check("xor", ALUResultM, 19'h0FF00);
      alu(3'b000, 19'hA, 19'h2, 1'b1, 19'h7FFFF);
      step();
      check("addi_res", ALUResultM, 19'h9);
      check("addi_wd",  WriteDataM, 19'h2);

      // Branch and jump resolution, checked combinationally in the same cycle
      br(2'b01, 1'b0, 19'h9, 19'h9, 15'h0010, 19'h4);
      check("beq_src", PCSrcE, 1);
      check("beq_tgt", PCTargetE, 15'h0014);
      br(2'b10, 1'b0, 19'h9, 19'h9, 15'h0010, 19'h4);   check("bne_src",  PCSrcE, 0);
      br(2'b10, 1'b0, 19'h9, 19'h8, 15'h0010, 19'h4);   check("bne_tk",   PCSrcE, 1);
      br(2'b11, 1'b0, 19'h40000, 19'h1, 15'h0, 19'h4);  check("blt_tk",   PCSrcE, 1);
      br(2'b11, 1'b0, 19'h1, 19'h40000, 15'h0, 19'h4);  check("blt_nt",   PCSrcE, 0);
      br(2'b00, 1'b0, 19'h9, 19'h9, 15'h0, 19'h4);      check("nobr",     PCSrcE, 0);
      ALUSrcE = 1'b1;
      br(2'b01, 1'b0, 19'h9, 19'h9, 15'h0010, 19'h4);   check("beq_imm",  PCSrcE, 1);
      ALUSrcE = 1'b0;
      br(2'b00, 1'b1, 19'h0, 19'h0, 15'h7FFF, 19'h2);
      check("jmp_src", PCSrcE, 1);
      check("jmp_tgt", PCTargetE, 15'h0001);
      br(2'b10, 1'b1, 19'h9, 19'h9, 15'h0100, 19'h10);
      check("jmp_br_src", PCSrcE, 1);
      check("jmp_br_tgt", PCTargetE, 15'h0110);
      BranchE = 2'b00;
      JumpE   = 1'b0;

      // Asynchronous reset mid-operation drops the in-flight bundle
      alu(3'b000, 19'h5, 19'h3, 1'b0, 19'h0);
      step();
      reset = 1'b0;
      #1;
      check("arst_alu", ALUResultM, 0);
      check("arst_rd",  RDM, 0);
      step();
      check("arst_hold", ALUResultM, 0);
      reset = 1'b1;

      // Back-to-back dependency scenario
      alu(3'b000, 19'h5, 19'h3, 1'b0, 19'h0);
      step();
      check("fw_c1", ALUResultM, 19'h8);
      ForwardAE = 2'b10;
      alu(3'b000, 19'h0, 19'h1, 1'b0, 19'h0);
      step();
`ifdef EXECUTE_FORWARD_EN
      check("fw_c2", ALUResultM, 19'h9);
`else
      check("fw_c2", ALUResultM, 19'h1);
`endif
      ForwardAE = 2'b00;
      ForwardBE = 2'b01;
      ResultW   = 19'h6;
      alu(3'b000, 19'h4, 19'h2, 1'b1, 19'h1);
      step();
      check("fw_c3_res", ALUResultM, 19'h5);
`ifdef EXECUTE_FORWARD_EN
      check("fw_c3_wd", WriteDataM, 19'h6);
`else
      check("fw_c3_wd", WriteDataM, 19'h2);
`endif
      ForwardBE = 2'b11;
      alu(3'b000, 19'h1, 19'h2, 1'b0, 19'h0);
      step();
      check("fw_rsvd", ALUResultM, 19'h3);
      ForwardBE = 2'b00;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
